// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between the in-order
// writeback stage (source A, priority) and a long-latency unit (source B).
// B is force-granted after STARVE_MAX consecutive denied cycles. A pending-write
// scoreboard tracks registers still owed by B.
// Optional feature macro: RF_WB_BYPASS_EN (zero-latency write port drive).
//
// Handshake: B presents b_valid with b_wa/b_data and holds all three stable
// until it sees b_ready high in the same cycle; a transfer happens on the
// rising edge where b_valid && b_ready. A is accepted whenever a_valid is high
// and a_stall is low; otherwise the pipeline holds its a_* inputs.
module rf_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  localparam int CW        = $clog2(STARVE_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_wa,
  input  logic [XLEN-1:0] a_data,
  output logic            a_stall,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_wa,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  input  logic [AW-1:0]   chk_ra1,
  input  logic [AW-1:0]   chk_ra2,
  output logic            busy1,
  output logic            busy2,
  output logic            reg_write,
  output logic [AW-1:0]   wa,
  output logic [XLEN-1:0] data_write,
  output logic            dbg_force,
  output logic [CW-1:0]   dbg_starve_cnt
);

  localparam int NREG = 1 << AW;

  typedef enum logic {NORM = 1'b0, FORCE_B = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              grant_a, grant_b, grant_any, wr_en;
  logic [AW-1:0]     grant_wa;
  logic [XLEN-1:0]   grant_data;

  // Grant selection and next-state; no grants at all while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    state_d = state_q;
    if (!rst) begin
      case (state_q)
        NORM: begin
          if (a_valid)      grant_a = 1'b1;
          else if (b_valid) grant_b = 1'b1;
          if (b_valid && !grant_b && starve_q == CW'(STARVE_MAX - 1))
            state_d = FORCE_B;
        end
        FORCE_B: begin
          grant_b = b_valid;
          // Either B is granted now or it dropped its request; both end the force.
          state_d = NORM;
        end
        default: state_d = NORM;
      endcase
    end
  end

  // Starvation counter: counts consecutive cycles B is requesting but denied.
  always_comb begin
    starve_d = '0;
    if (b_valid && !grant_b) starve_d = starve_q + 1'b1;
  end

  // Write-port request mux shared by registered and bypass output paths.
  always_comb begin
    grant_any  = grant_a | grant_b;
    grant_wa   = grant_b ? b_wa : a_wa;
    grant_data = grant_b ? b_data : a_data;
    wr_en      = grant_any && (grant_wa != '0);
  end

  // Scoreboard next value: B grant clears, allocate sets, set wins on a tie.
  always_comb begin
    busy_d = busy_q;
    if (grant_b) busy_d[b_wa] = 1'b0;
    if (alloc_valid && alloc_rd != '0) busy_d[alloc_rd] = 1'b1;
  end

  // State, counter and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= NORM;
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Zero-latency drive of the register file write port from the granted request.
  always_comb begin
    reg_write  = wr_en;
    wa         = grant_any ? grant_wa : '0;
    data_write = grant_any ? grant_data : '0;
  end
`else
  // One-cycle output register; address/data hold when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      wa         <= '0;
      data_write <= '0;
    end else begin
      reg_write <= wr_en;
      if (wr_en) begin
        wa         <= grant_wa;
        data_write <= grant_data;
      end
    end
  end
`endif

  // Handshake outputs, scoreboard lookups and debug view of the FSM.
  always_comb begin
    b_ready        = grant_b;
    a_stall        = a_valid && !grant_a;
    busy1          = (chk_ra1 != '0) && busy_q[chk_ra1];
    busy2          = (chk_ra2 != '0) && busy_q[chk_ra2];
    dbg_force      = (state_q == FORCE_B);
    dbg_starve_cnt = starve_q;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter (default registered write path).
module tb_rf_wb_arbiter;
  localparam int SM   = 4;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CW   = $clog2(SM + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, b_valid, alloc_valid;
  logic [AW-1:0]   a_wa, b_wa, alloc_rd, chk_ra1, chk_ra2;
  logic [XLEN-1:0] a_data, b_data;
  logic            a_stall, b_ready, busy1, busy2, reg_write, dbg_force;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] data_write;
  logic [CW-1:0]   dbg_starve_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.STARVE_MAX(SM), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wa(a_wa), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_wa(b_wa), .b_data(b_data), .b_ready(b_ready),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .busy1(busy1), .busy2(busy2),
    .reg_write(reg_write), .wa(wa), .data_write(data_write),
    .dbg_force(dbg_force), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // B must hold request and payload until accepted
  logic            p_pend = 1'b0;
  logic [AW-1:0]   p_wa;
  logic [XLEN-1:0] p_data;
  always @(posedge clk) begin
    if (p_pend)
      assert (b_valid && b_wa == p_wa && b_data == p_data)
        else $error("FAIL b_hold: B request changed before b_ready");
    p_pend <= b_valid && !b_ready;
    p_wa   <= b_wa;
    p_data <= b_data;
  end

  task automatic idle_inputs();
    a_valid = 0; a_wa = 0; a_data = 0;
    b_valid = 0; b_wa = 0; b_data = 0;
    alloc_valid = 0; alloc_rd = 0; chk_ra1 = 0; chk_ra2 = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    a_valid = 1; a_wa = 5'd3;
    #1;
    n_cmp++;
    if (reg_write !== 1'b0 || wa !== '0 || data_write !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got rw=%b wa=%0d d=%h required 0/0/0", reg_write, wa, data_write);
    end
    n_cmp++;
    if (b_ready !== 1'b0 || a_stall !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: got b_ready=%b a_stall=%b busy1=%b required 0/1/0", b_ready, a_stall, busy1);
    end
    n_cmp++;
    if (dbg_force !== 1'b0 || dbg_starve_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_fsm: got force=%b cnt=%0d required 0/0", dbg_force, dbg_starve_cnt);
    end
    @(negedge clk);
    a_valid = 0; a_wa = 0;
    rst = 0;
  endtask

  task automatic test_a_write();
    @(negedge clk);
    a_valid = 1; a_wa = 5'd5; a_data = 32'h0000_1234;
    #1;
    n_cmp++;
    if (a_stall !== 1'b0) begin
      n_fail++; $display("FAIL a_accept: got a_stall=%b required 0", a_stall);
    end
    @(negedge clk);
    a_valid = 0;
    n_cmp++;
    if (reg_write !== 1'b1 || wa !== 5'd5 || data_write !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL a_write: got rw=%b wa=%0d d=%h required 1/5/00001234", reg_write, wa, data_write);
    end
    @(negedge clk);
    n_cmp++;
    if (reg_write !== 1'b0) begin
      n_fail++; $display("FAIL a_write_end: got rw=%b required 0", reg_write);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    alloc_valid = 1; alloc_rd = 5'd7; chk_ra1 = 5'd7;
    @(negedge clk);
    alloc_valid = 0;
    #1;
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL sb_set: got busy1=%b required 1", busy1);
    end
    b_valid = 1; b_wa = 5'd7; b_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (b_ready !== 1'b1) begin
      n_fail++; $display("FAIL sb_b_ready: got b_ready=%b required 1", b_ready);
    end
    @(negedge clk);
    b_valid = 0;
    #1;
    n_cmp++;
    if (reg_write !== 1'b1 || wa !== 5'd7 || data_write !== 32'hDEAD_BEEF || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear: got rw=%b wa=%0d d=%h busy1=%b required 1/7/deadbeef/0",
               reg_write, wa, data_write, busy1);
    end
  endtask

  task automatic test_starve();
    @(negedge clk);
    a_valid = 1; a_wa = 5'd3; a_data = 32'h33;
    b_valid = 1; b_wa = 5'd4; b_data = 32'h44;
    for (int i = 1; i <= SM; i++) begin
      #1;
      n_cmp++;
      if (b_ready !== 1'b0 || a_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_deny c%0d: got b_ready=%b a_stall=%b required 0/0", i, b_ready, a_stall);
      end
      if (i == SM) begin
        n_cmp++;
        if (dbg_starve_cnt !== CW'(SM - 1)) begin
          n_fail++; $display("FAIL starve_cnt: got %0d required %0d", dbg_starve_cnt, SM - 1);
        end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (b_ready !== 1'b1 || a_stall !== 1'b1 || dbg_force !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_force: got b_ready=%b a_stall=%b force=%b required 1/1/1", b_ready, a_stall, dbg_force);
    end
    @(negedge clk);
    b_valid = 0;
    n_cmp++;
    if (reg_write !== 1'b1 || wa !== 5'd4 || data_write !== 32'h44) begin
      n_fail++;
      $display("FAIL starve_bwrite: got rw=%b wa=%0d d=%h required 1/4/44", reg_write, wa, data_write);
    end
    #1;
    n_cmp++;
    if (a_stall !== 1'b0 || dbg_starve_cnt !== '0 || dbg_force !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_after: got a_stall=%b cnt=%0d force=%b required 0/0/0", a_stall, dbg_starve_cnt, dbg_force);
    end
    @(negedge clk);
    a_valid = 0;
    n_cmp++;
    if (reg_write !== 1'b1 || wa !== 5'd3 || data_write !== 32'h33) begin
      n_fail++;
      $display("FAIL starve_awrite: got rw=%b wa=%0d d=%h required 1/3/33", reg_write, wa, data_write);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    a_valid = 1; a_wa = 5'd0; a_data = 32'hFFFF_FFFF;
    alloc_valid = 1; alloc_rd = 5'd0; chk_ra1 = 5'd0;
    #1;
    n_cmp++;
    if (a_stall !== 1'b0) begin
      n_fail++; $display("FAIL x0_accept: got a_stall=%b required 0", a_stall);
    end
    @(negedge clk);
    a_valid = 0; alloc_valid = 0;
    #1;
    n_cmp++;
    if (reg_write !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL x0_write: got rw=%b busy1=%b required 0/0", reg_write, busy1);
    end
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    alloc_valid = 1; alloc_rd = 5'd9; chk_ra1 = 5'd9;
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL tie_pre: got busy1=%b required 1", busy1);
    end
    b_valid = 1; b_wa = 5'd9; b_data = 32'h9999_0009;
    #1;
    n_cmp++;
    if (b_ready !== 1'b1) begin
      n_fail++; $display("FAIL tie_b_ready: got %b required 1", b_ready);
    end
    @(negedge clk);
    b_valid = 0; alloc_valid = 0;
    #1;
    n_cmp++;
    if (busy1 !== 1'b1 || reg_write !== 1'b1 || wa !== 5'd9 || data_write !== 32'h9999_0009) begin
      n_fail++;
      $display("FAIL tie_result: got busy1=%b rw=%b wa=%0d d=%h required 1/1/9/99990009",
               busy1, reg_write, wa, data_write);
    end
  endtask

  task automatic test_reset_force();
    @(negedge clk);
    a_valid = 1; a_wa = 5'd6; a_data = 32'h66;
    b_valid = 1; b_wa = 5'd13; b_data = 32'h0B0B;
    alloc_valid = 1; alloc_rd = 5'd12; chk_ra1 = 5'd12;
    repeat (SM) begin
      @(negedge clk);
      alloc_valid = 0;
    end
    #1;
    n_cmp++;
    if (dbg_force !== 1'b1 || busy1 !== 1'b1 || reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rf_pre: got force=%b busy1=%b rw=%b required 1/1/1", dbg_force, busy1, reg_write);
    end
    rst = 1;
    #1;
    n_cmp++;
    if (reg_write !== 1'b0 || wa !== '0 || data_write !== '0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rf_clear: got rw=%b wa=%0d d=%h busy1=%b required 0/0/0/0", reg_write, wa, data_write, busy1);
    end
    n_cmp++;
    if (dbg_starve_cnt !== '0 || dbg_force !== 1'b0 || b_ready !== 1'b0 || a_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rf_state: got cnt=%0d force=%b b_ready=%b a_stall=%b required 0/0/0/1",
               dbg_starve_cnt, dbg_force, b_ready, a_stall);
    end
    @(negedge clk);
    n_cmp++;
    if (b_ready !== 1'b0) begin
      n_fail++; $display("FAIL rf_hold: got b_ready=%b required 0", b_ready);
    end
    rst = 0; a_valid = 0;
    #1;
    n_cmp++;
    if (b_ready !== 1'b1 || a_stall !== 1'b0 || dbg_force !== 1'b0) begin
      n_fail++;
      $display("FAIL rf_regrant: got b_ready=%b a_stall=%b force=%b required 1/0/0", b_ready, a_stall, dbg_force);
    end
    @(negedge clk);
    b_valid = 0;
    n_cmp++;
    if (reg_write !== 1'b1 || wa !== 5'd13 || data_write !== 32'h0B0B) begin
      n_fail++;
      $display("FAIL rf_bwrite: got rw=%b wa=%0d d=%h required 1/13/b0b", reg_write, wa, data_write);
    end
  endtask

  // Random traffic against a model: B is forced once it has waited SM cycles.
  task automatic test_random();
    int                   b_wait;
    logic [31:0]          mbusy;
    logic [AW+XLEN-1:0]   exp_q[$];
    logic [AW+XLEN-1:0]   ent;
    logic [AW-1:0]        e_wa;
    logic [XLEN-1:0]      e_data;
    logic                 frc, ga, gb, b_acc;
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    b_wait = 0; mbusy = '0; e_wa = '0; e_data = '0; b_acc = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        e_wa = ent[AW+XLEN-1:XLEN];
        e_data = ent[XLEN-1:0];
        if (reg_write !== 1'b1 || wa !== e_wa || data_write !== e_data) begin
          n_fail++;
          $display("FAIL rnd_write c%0d: got rw=%b wa=%0d d=%h required 1/%0d/%h",
                   cyc, reg_write, wa, data_write, e_wa, e_data);
        end
      end else if (reg_write !== 1'b0 || wa !== e_wa || data_write !== e_data) begin
        n_fail++;
        $display("FAIL rnd_idle c%0d: got rw=%b wa=%0d d=%h required 0/%0d/%h",
                 cyc, reg_write, wa, data_write, e_wa, e_data);
      end
      n_cmp++;
      if (busy1 !== mbusy[chk_ra1] || busy2 !== mbusy[chk_ra2]) begin
        n_fail++;
        $display("FAIL rnd_busy c%0d: got %b%b required %b%b",
                 cyc, busy1, busy2, mbusy[chk_ra1], mbusy[chk_ra2]);
      end
      a_valid = ($urandom_range(0, 99) < 65);
      a_wa    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      a_data  = $urandom;
      if (!b_valid || b_acc) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_wa    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        b_data  = $urandom;
      end
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_rd    = AW'($urandom);
      chk_ra1     = AW'($urandom);
      chk_ra2     = AW'($urandom);
      #1;
      frc = b_valid && (b_wait >= SM);
      ga  = a_valid && !frc;
      gb  = b_valid && !ga;
      n_cmp++;
      if (a_stall !== (a_valid && !ga) || b_ready !== gb) begin
        n_fail++;
        $display("FAIL rnd_grant c%0d: got a_stall=%b b_ready=%b required %b/%b",
                 cyc, a_stall, b_ready, a_valid && !ga, gb);
      end
      b_acc  = gb;
      b_wait = (b_valid && !gb) ? b_wait + 1 : 0;
      if (gb) mbusy[b_wa] = 1'b0;
      if (alloc_valid && alloc_rd != '0) mbusy[alloc_rd] = 1'b1;
      if (ga && a_wa != '0) exp_q.push_back({a_wa, a_data});
      else if (gb && b_wa != '0) exp_q.push_back({b_wa, b_data});
    end
    @(negedge clk);
    a_valid = 0; alloc_valid = 0;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_a_write();
    test_scoreboard();
    test_starve();
    test_x0();
    test_set_wins();
    test_reset_force();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
